// File: rtl/vfp_config_sequencer.sv
`default_nettype none
// ============================================================================
// vfp_config_sequencer : replays a register table over AXI4-Lite, then reads
// back one revision word.                                   Revision: 1.0
// ============================================================================
module vfp_config_sequencer #(
  parameter int C_vfpConfig_ADDR_WIDTH = 8,
  parameter int C_vfpConfig_DATA_WIDTH = 32,
  parameter int NUM_REGS               = 16,
  parameter int REV_ADDR               = 0,
  parameter int TIMEOUT                = 255,
  localparam int ADDR_W = C_vfpConfig_ADDR_WIDTH,
  localparam int DATA_W = C_vfpConfig_DATA_WIDTH,
  localparam int IDX_W  = $clog2(NUM_REGS),
  localparam int CNT_W  = IDX_W + 1
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                start,
  input  logic [CNT_W-1:0]    count,
  input  logic                tbl_we,
  input  logic [IDX_W-1:0]    tbl_idx,
  input  logic [ADDR_W-1:0]   tbl_addr,
  input  logic [DATA_W-1:0]   tbl_data,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CNT_W-1:0]    err_idx,
  output logic [DATA_W-1:0]   rev_data,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [2:0]          AWPROT,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [2:0]          ARPROT,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_RADDR = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  logic [ADDR_W-1:0] r_tbl_addr [NUM_REGS];
  logic [DATA_W-1:0] r_tbl_data [NUM_REGS];

  logic [2:0]        r_state, w_next;
  logic [CNT_W-1:0]  r_idx, r_cnt, w_idx_n, w_cnt_n, w_cnt_sat;
  logic [TMR_W-1:0]  r_wait;
  logic              r_aw_done, r_w_done;
  logic              w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic              w_aw_ok, w_w_ok, w_wait_st, w_timeout;
  logic              w_awvalid_n, w_wvalid_n, w_bready_n, w_arvalid_n, w_rready_n;
  logic              w_busy_n, w_done_n, w_err_n;
  logic [CNT_W-1:0]  w_err_idx_n;
  logic [ADDR_W-1:0] w_awaddr_n, w_araddr_n;
  logic [DATA_W-1:0] w_wdata_n, w_rev_n;

  assign AWPROT = 3'b000;
  assign ARPROT = 3'b000;
  assign WSTRB  = '1;

  assign w_aw_hs   = AWVALID & AWREADY;
  assign w_w_hs    = WVALID & WREADY;
  assign w_b_hs    = BVALID & BREADY;
  assign w_ar_hs   = ARVALID & ARREADY;
  assign w_r_hs    = RVALID & RREADY;
  assign w_aw_ok   = r_aw_done | w_aw_hs;
  assign w_w_ok    = r_w_done | w_w_hs;
  assign w_wait_st = (r_state == S_WADDR) || (r_state == S_WRESP) ||
                     (r_state == S_RADDR) || (r_state == S_RDATA);
  assign w_timeout = w_wait_st && (r_wait == TMR_W'(TIMEOUT - 1));
  assign w_cnt_sat = (count > CNT_W'(NUM_REGS)) ? CNT_W'(NUM_REGS) : count;

  // Table storage has no reset; its contents are meaningless after ARESETN.
  always_ff @(posedge ACLK) begin
    if (tbl_we && !busy) begin
      r_tbl_addr[tbl_idx] <= tbl_addr;
      r_tbl_data[tbl_idx] <= tbl_data;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_wait    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      AWADDR    <= '0;
      WDATA     <= '0;
      ARADDR    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_idx   <= '0;
      rev_data  <= '0;
    end else begin
      r_state   <= w_next;
      r_idx     <= w_idx_n;
      r_cnt     <= w_cnt_n;
      r_wait    <= (w_next != r_state) ? '0 :
                   (w_wait_st ? r_wait + TMR_W'(1) : r_wait);
      r_aw_done <= (r_state == S_WADDR) ? w_aw_ok : 1'b0;
      r_w_done  <= (r_state == S_WADDR) ? w_w_ok : 1'b0;
      AWVALID   <= w_awvalid_n;
      WVALID    <= w_wvalid_n;
      BREADY    <= w_bready_n;
      ARVALID   <= w_arvalid_n;
      RREADY    <= w_rready_n;
      AWADDR    <= w_awaddr_n;
      WDATA     <= w_wdata_n;
      ARADDR    <= w_araddr_n;
      busy      <= w_busy_n;
      done      <= w_done_n;
      err       <= w_err_n;
      err_idx   <= w_err_idx_n;
      rev_data  <= w_rev_n;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (count == '0) ? S_RADDR : S_WADDR;
      S_WADDR: begin
        if (w_aw_ok && w_w_ok) w_next = S_WRESP;
        else if (w_timeout)    w_next = S_FIN;
      end
      S_WRESP: begin
        if (w_b_hs)         w_next = (BRESP == 2'b00) ? S_NEXT : S_FIN;
        else if (w_timeout) w_next = S_FIN;
      end
      S_NEXT:  w_next = ((r_idx + CNT_W'(1)) == r_cnt) ? S_RADDR : S_WADDR;
      S_RADDR: begin
        if (w_ar_hs)        w_next = S_RDATA;
        else if (w_timeout) w_next = S_FIN;
      end
      S_RDATA: if (w_r_hs || w_timeout) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_idx_n     = r_idx;
    w_cnt_n     = r_cnt;
    w_err_n     = err;
    w_err_idx_n = err_idx;
    w_rev_n     = rev_data;
    w_awaddr_n  = AWADDR;
    w_wdata_n   = WDATA;
    w_araddr_n  = ARADDR;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_idx_n     = '0;
          w_cnt_n     = w_cnt_sat;
          w_err_n     = 1'b0;
          w_err_idx_n = '0;
        end
      end
      // In the write states FIN is only reached through an error response or timeout.
      S_WADDR, S_WRESP: begin
        if (w_next == S_FIN) begin
          w_err_n     = 1'b1;
          w_err_idx_n = r_idx;
        end
      end
      S_NEXT:  w_idx_n = r_idx + CNT_W'(1);
      S_RADDR: begin
        if (w_next == S_FIN) begin
          w_err_n     = 1'b1;
          w_err_idx_n = CNT_W'(NUM_REGS);
        end
      end
      S_RDATA: begin
        if (w_r_hs) begin
          w_rev_n = RDATA;
          if (RRESP != 2'b00) begin
            w_err_n     = 1'b1;
            w_err_idx_n = CNT_W'(NUM_REGS);
          end
        end else if (w_timeout) begin
          w_err_n     = 1'b1;
          w_err_idx_n = CNT_W'(NUM_REGS);
        end
      end
      default: ;
    endcase

    if ((w_next == S_WADDR) && (r_state != S_WADDR)) begin
      w_awaddr_n = r_tbl_addr[w_idx_n[IDX_W-1:0]];
      w_wdata_n  = r_tbl_data[w_idx_n[IDX_W-1:0]];
    end
    if (w_next == S_RADDR) w_araddr_n = ADDR_W'(REV_ADDR);

    w_awvalid_n = (w_next == S_WADDR) && !((r_state == S_WADDR) && w_aw_ok);
    w_wvalid_n  = (w_next == S_WADDR) && !((r_state == S_WADDR) && w_w_ok);
    w_bready_n  = (w_next == S_WRESP);
    w_arvalid_n = (w_next == S_RADDR);
    w_rready_n  = (w_next == S_RDATA);
    w_busy_n    = (w_next != S_IDLE) && (w_next != S_FIN);
    w_done_n    = (w_next == S_FIN);
  end

endmodule
`default_nettype wire

// File: doc/vfp_config_sequencer.md
VFP_CONFIG_SEQUENCER -- requirements
Module: vfp_config_sequencer

Interface
REQ-001 The block SHALL have parameter C_vfpConfig_ADDR_WIDTH, default 8, giving the AXI4-Lite address width.
REQ-002 The block SHALL have parameter C_vfpConfig_DATA_WIDTH, default 32, giving the AXI4-Lite data width.
REQ-003 The block SHALL have parameter NUM_REGS, default 16, giving the table depth (power of 2).
REQ-004 The block SHALL have parameter REV_ADDR, default 0, giving the read-back register address.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, giving the maximum handshake wait in cycles.
REQ-006 The block SHALL run on one clock with an asynchronous, active-low reset, both listed first among the ports below.
REQ-007 The block SHALL have the following ports (name, direction, width, meaning):
- ACLK  in  1  clock
- ARESETN  in  1  async active-low reset
- start  in  1  begin sequence (pulse)
- count  in  log2(NUM_REGS)+1  number of table entries to write
- tbl_we  in  1  table write strobe
- tbl_idx  in  log2(NUM_REGS)  table index
- tbl_addr  in  ADDR_W  register address
- tbl_data  in  DATA_W  register data
- busy  out  1  sequence active
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error of last sequence
- err_idx  out  log2(NUM_REGS)+1  failing entry; NUM_REGS means read-back failure
- rev_data  out  DATA_W  RDATA captured from REV_ADDR
- AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  AXI4-Lite master; widths are ADDR_W, 3, 1, DATA_W, DATA_W/8, 2 as standard.

Function
REQ-008 tbl_we SHALL write {tbl_addr,tbl_data} at tbl_idx on the rising edge; it SHALL be ignored while busy=1.
REQ-009 FSM states SHALL be IDLE, WADDR, WRESP, NEXT, RADDR, RDATA, FIN.
REQ-010 In IDLE, start=1 SHALL latch count (saturated to NUM_REGS), clear err, err_idx and entry index i, set busy=1 next cycle, and enter WADDR, or RADDR if count=0.
REQ-011 start while busy=1 SHALL be ignored.
REQ-012 In WADDR, AWVALID and WVALID SHALL be asserted together with AWADDR=table[i].addr, WDATA=table[i].data, WSTRB=all ones, AWPROT=0.
REQ-013 Each of AWVALID and WVALID SHALL deassert independently on its own ready handshake; address and data SHALL be held stable while valid is high.
REQ-014 When both AW and W have been accepted, the FSM SHALL enter WRESP, where BREADY=1.
REQ-015 On BVALID in WRESP: BRESP=00 -> NEXT; BRESP!=00 -> err=1, err_idx=i, FIN (abort; remaining entries not written).
REQ-016 NEXT SHALL increment i: if i+1=count -> RADDR, else -> WADDR.
REQ-017 RADDR SHALL assert ARVALID with ARADDR=REV_ADDR, ARPROT=0 until ARREADY, then enter RDATA.
REQ-018 RDATA SHALL assert RREADY; on RVALID, rev_data<=RDATA; RRESP!=00 -> err=1, err_idx=NUM_REGS; then -> FIN.
REQ-019 FIN SHALL pulse done=1 for exactly one cycle, drop busy on the same edge, and return to IDLE.
REQ-020 A wait counter SHALL reset on each state entry and count cycles spent in WADDR, WRESP, RADDR and RDATA.
REQ-021 When the wait counter reaches TIMEOUT, the block SHALL set err=1 with err_idx=i (or NUM_REGS in the read states), drop all VALID/READY outputs, and enter FIN.
REQ-022 err, err_idx and rev_data SHALL hold until the next accepted start.
REQ-023 Start-to-AWVALID latency SHALL be 1 cycle.

Reset
REQ-024 ARESETN=0 SHALL immediately force IDLE and drive all AXI VALID/READY outputs, busy, done, err, err_idx, rev_data, AWADDR, WDATA and ARADDR to 0.
REQ-025 Reset during an outstanding transaction SHALL abandon it; table contents are undefined after reset.
REQ-026 Outputs SHALL be registered.

Verification
REQ-027 Load 3 entries {0x04:0x1,0x08:0xAB,0x0C:0x5}, count=3, slave always ready, OKAY responses -> writes issued in order, one ARADDR=REV_ADDR read, rev_data=RDATA, done pulse once, err=0.
REQ-028 Slave raises AWREADY 2 cycles before WREADY (and the reverse) -> each VALID drops only on its own handshake, with a single write per entry.
REQ-029 BRESP=10 on entry 1 of 3 -> err=1, err_idx=1, entry 2 never issued, no read, done pulses.
REQ-030 BVALID withheld, TIMEOUT=255 -> after 255 cycles err=1, err_idx=current i, BREADY=0, done pulses.
REQ-031 count=0 -> no AW/W activity, read only, done; start pulsed mid-sequence and tbl_we while busy -> no effect.
REQ-032 ARESETN low while AWVALID=1 -> all outputs 0 asynchronously, IDLE; a new start after release runs normally.
